// File: rtl/ram_scan_viewer.sv
// Dual-port word memory whose read side follows a manual address or an auto-scan pointer.
// Read data is returned together with the address it came from.
module ram_scan_viewer #(
  parameter int DATA_W      = 3,
  parameter int ADDR_W      = 5,
  parameter int TICK_CYCLES = 33554432
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              pause,
  input  logic              restart,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              tick,
  output logic              sweep_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(TICK_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

  localparam logic [1:0] MODE_MAN   = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_SWEEP = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        mode_q;
  logic              mode_vld;
  logic              rearm;
  logic [ADDR_W-1:0] rd_sel;

  assign rd_sel = (mode == MODE_MAN) ? man_addr : scan_addr;
  // mode_vld masks the first cycle after reset, where no previous mode exists yet
  assign rearm  = restart || (mode_vld && (mode != mode_q));
  assign tick   = (mode != MODE_MAN) && !pause && (cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: the registered read sees the word before a same-edge write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_addr  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= mem[rd_sel];
      rd_addr  <= rd_sel;
      rd_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      scan_addr  <= '0;
      sweep_done <= 1'b0;
      mode_q     <= MODE_MAN;
      mode_vld   <= 1'b0;
    end else begin
      mode_q   <= mode;
      mode_vld <= 1'b1;
      if (rearm) begin
        cnt        <= '0;
        scan_addr  <= (mode == MODE_DOWN) ? ADDR_TOP : '0;
        sweep_done <= 1'b0;
      end else if (mode == MODE_MAN) begin
        cnt <= '0;
      end else if (!pause) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          case (mode)
            MODE_UP:   scan_addr <= scan_addr + 1'b1;
            MODE_DOWN: scan_addr <= scan_addr - 1'b1;
            MODE_SWEEP: begin
              if (scan_addr == ADDR_TOP) sweep_done <= 1'b1;
              else                       scan_addr  <= scan_addr + 1'b1;
            end
            default: ;
          endcase
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_scan_viewer.sv
// Directed bench for ram_scan_viewer with a 4-cycle scan tick and a 32x3 memory.
module tb_ram_scan_viewer;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       pause;
  logic       restart;
  logic [4:0] man_addr;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [2:0] wr_data;
  logic [2:0] rd_data;
  logic [4:0] rd_addr;
  logic       rd_valid;
  logic [4:0] scan_addr;
  logic       tick;
  logic       sweep_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] exp_mem [32];
  logic [4:0] exp_scan;
  logic [4:0] exp_rd;
  int         exp_cnt;
  logic       exp_done;

  ram_scan_viewer #(.DATA_W(3), .ADDR_W(5), .TICK_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .mode(mode), .pause(pause), .restart(restart),
    .man_addr(man_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .scan_addr(scan_addr), .tick(tick), .sweep_done(sweep_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data"},    32'(rd_data),    0);
    chk({tag, "_rd_addr"},    32'(rd_addr),    0);
    chk({tag, "_rd_valid"},   32'(rd_valid),   0);
    chk({tag, "_scan_addr"},  32'(scan_addr),  0);
    chk({tag, "_tick"},       32'(tick),       0);
    chk({tag, "_sweep_done"}, 32'(sweep_done), 0);
  endtask

  // One scanning cycle: compare against the model, clock once, advance the model
  task automatic tick_cycle();
    logic       exp_tick;
    logic [4:0] next_rd;
    exp_tick = (mode != 2'b00) && !pause && (exp_cnt == 3);
    chk("tick",       32'(tick),       32'(exp_tick));
    chk("scan_addr",  32'(scan_addr),  32'(exp_scan));
    chk("sweep_done", 32'(sweep_done), 32'(exp_done));
    chk("scan_rd_addr", 32'(rd_addr),  32'(exp_rd));
    chk("scan_rd_data", 32'(rd_data),  32'(exp_mem[exp_rd]));
    next_rd = exp_scan;
    step();
    exp_rd = next_rd;
    if (mode != 2'b00 && !pause) begin
      if (exp_cnt == 3) begin
        exp_cnt = 0;
        case (mode)
          2'b01: exp_scan = exp_scan + 5'd1;
          2'b10: exp_scan = exp_scan - 5'd1;
          default: begin
            if (exp_scan == 5'd31) exp_done = 1'b1;
            else                   exp_scan = exp_scan + 5'd1;
          end
        endcase
      end else begin
        exp_cnt++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick_cycle();
  endtask

  // Rearm by mode change, or by a restart pulse when the mode is unchanged
  task automatic rearm(input logic [1:0] m);
    exp_rd = exp_scan;
    if (m == mode) restart = 1'b1;
    mode = m;
    step();
    restart  = 1'b0;
    exp_scan = (m == 2'b10) ? 5'd31 : 5'd0;
    exp_cnt  = 0;
    exp_done = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b0; mode = 2'b00; pause = 1'b0; restart = 1'b0;
    man_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #3;
    chk_all_zero("por");
    step();
    step();
    chk_all_zero("in_reset");
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 3'(i % 8);
      exp_mem[i] = 3'(i % 8);
      step();
    end
    wr_en = 1'b0;

    for (int i = 0; i < 32; i++) begin
      man_addr = 5'(i);
      step();
      chk("man_rd_data",  32'(rd_data),  32'(i % 8));
      chk("man_rd_addr",  32'(rd_addr),  32'(i));
      chk("man_rd_valid", 32'(rd_valid), 1);
    end
    chk("man_tick", 32'(tick), 0);

    man_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 3'd5;
    step();
    wr_en = 1'b0;
    chk("rdfirst_old", 32'(rd_data), 7);
    exp_mem[7] = 3'd5;
    step();
    chk("rdfirst_new", 32'(rd_data), 5);

    exp_scan = 5'd0; exp_cnt = 0; exp_done = 1'b0;
    rearm(2'b01);
    run(33 * 4);

    rearm(2'b10);
    run(14);
    pause = 1'b1;
    run(10);
    pause = 1'b0;
    run(32 * 4);

    rearm(2'b11);
    run(40 * 4);
    chk("sweep_held", 32'(scan_addr), 31);
    rearm(2'b11);
    run(4);

    rearm(2'b01);
    guard = 0;
    while (exp_scan != 5'd12 && guard < 300) begin
      tick_cycle();
      guard++;
    end
    chk("reach_scan12", 32'(scan_addr), 12);
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step();
    step();
    reset = 1'b1;
    exp_scan = 5'd0; exp_cnt = 0; exp_done = 1'b0; exp_rd = 5'd0;
    run(20);
    chk("post_reset_scan", 32'(scan_addr), 5);

    mode = 2'b00; man_addr = 5'd12;
    step();
    chk("mem_kept_data",  32'(rd_data),  4);
    chk("mem_kept_addr",  32'(rd_addr),  12);
    chk("mem_kept_valid", 32'(rd_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
